// File: rtl/column_approx_seq_ctrl_pkg.sv
// Shared types and helpers for the column-truncated approximate multiplier family.
package column_approx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_LENGTH = 8;

  // Truncation levels beyond the operand width behave like full-width truncation.
  function automatic int unsigned clamp_theta(input int unsigned theta, input int unsigned length);
    return (theta > length) ? length : theta;
  endfunction

endpackage

// File: rtl/column_approx_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential approximate multiplier.
interface column_approx_seq_ctrl_if
  import column_approx_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH,
  parameter int TW     = $clog2(LENGTH + 1)
);

  logic                  in_valid;
  logic                  in_ready;
  logic [LENGTH-1:0]     x;
  logic [LENGTH-1:0]     y;
  logic [TW-1:0]         theta;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*LENGTH-1:0]   z;
  logic                  busy;

  modport master (
    output in_valid, x, y, theta, out_ready,
    input  in_ready, out_valid, z, busy
  );

  modport slave (
    input  in_valid, x, y, theta, out_ready,
    output in_ready, out_valid, z, busy
  );

endinterface

// File: rtl/column_approx_seq_ctrl_row_gen.sv
// One masked, shifted partial-product row: low k bits of x are cleared,
// where k = max(theta - idx, 0), then the row is placed at weight 2^idx.
module column_row_gen
  import column_approx_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH,
  parameter int TW     = $clog2(LENGTH + 1),
  parameter int IW     = (LENGTH > 1) ? $clog2(LENGTH) : 1
) (
  input  logic [LENGTH-1:0]   x,
  input  logic                y_bit,
  input  logic [IW-1:0]       idx,
  input  logic [TW-1:0]       theta,
  output logic [2*LENGTH-1:0] row
);

  logic [TW-1:0]         idx_w;
  logic [TW-1:0]         k;
  logic [2*LENGTH-1:0]   x_w;
  logic [2*LENGTH-1:0]   masked;

  // Widen x before shifting so the row never loses high bits.
  always_comb begin
    idx_w  = TW'(idx);
    k      = (theta > idx_w) ? (theta - idx_w) : '0;
    x_w    = {{LENGTH{1'b0}}, x};
    masked = (x_w >> k) << k;
    row    = y_bit ? (masked << idx) : '0;
  end

endmodule

// File: rtl/column_approx_seq_ctrl.sv
// Sequential column-truncated approximate multiplier: one partial-product
// row per cycle through a shared row generator into a 2*LENGTH accumulator.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for an operand pair; in_ready high
// CALC  | adding row cnt each cycle, LENGTH cycles, no zero-bit skipping
// DONE  | product on z with out_valid; held until out_ready
module column_approx_seq_ctrl
  import column_approx_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH,
  parameter int TW     = $clog2(LENGTH + 1)
) (
  input logic                      clk,
  input logic                      rst,
  column_approx_seq_ctrl_if.slave  bus
);

  localparam int IW = (LENGTH > 1) ? $clog2(LENGTH) : 1;
  localparam int PW = 2 * LENGTH;

  state_t              state;
  state_t              state_nxt;
  logic [LENGTH-1:0]   x_l;
  logic [LENGTH-1:0]   y_l;
  logic [TW-1:0]       theta_l;
  logic [IW-1:0]       cnt;
  logic [PW-1:0]       acc;
  logic [PW-1:0]       row;
  logic                accept;
  logic                last_row;
  logic                in_ready_c;
  logic                out_valid_c;
  logic                busy_c;

  assign accept   = (state == IDLE) && bus.in_valid;
  assign last_row = (cnt == IW'(LENGTH - 1));

  column_row_gen #(
    .LENGTH (LENGTH),
    .TW     (TW),
    .IW     (IW)
  ) u_row_gen (
    .x     (x_l),
    .y_bit (y_l[cnt]),
    .idx   (cnt),
    .theta (theta_l),
    .row   (row)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; in_ready only in IDLE prevents overlap.
  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    busy_c      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_nxt = CALC;
      end
      CALC: begin
        busy_c = 1'b1;
        if (last_row) state_nxt = DONE;
      end
      DONE: begin
        busy_c      = 1'b1;
        out_valid_c = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch on accept, then one row accumulated per CALC cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_l     <= '0;
      y_l     <= '0;
      theta_l <= '0;
      cnt     <= '0;
      acc     <= '0;
    end else if (accept) begin
      x_l     <= bus.x;
      y_l     <= bus.y;
      theta_l <= TW'(clamp_theta(32'(bus.theta), LENGTH));
      cnt     <= '0;
      acc     <= '0;
    end else if (state == CALC) begin
      acc <= acc + row;
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.busy      = busy_c;
  assign bus.z         = acc;

endmodule

// File: tb/tb_column_approx_seq_ctrl.sv
// Scoreboard bench for column_approx_seq_ctrl: directed corner cases plus
// randomized traffic against a column-view reference model.
module tb_column_approx_seq_ctrl;
  import column_approx_pkg::*;

  localparam int LENGTH = 8;
  localparam int TW     = $clog2(LENGTH + 1);
  localparam int PW     = 2 * LENGTH;

  logic clk = 1'b0;
  logic rst = 1'b1;

  column_approx_seq_ctrl_if #(.LENGTH(LENGTH), .TW(TW)) bus();

  column_approx_seq_ctrl #(.LENGTH(LENGTH), .TW(TW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;
  int n_out    = 0;
  int rdy_mode = 0;   // 0: always ready, 1: random stalls, 2: hold off
  logic [PW-1:0] sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Column view: bit x[j]*y[i] lands in column i+j and survives only if i+j >= theta.
  function automatic logic [PW-1:0] ref_z(input int xv, input int yv, input int tv);
    int    t;
    longint s;
    t = (tv > LENGTH) ? LENGTH : tv;
    s = 0;
    for (int i = 0; i < LENGTH; i++)
      for (int j = 0; j < LENGTH; j++)
        if (yv[i] && xv[j] && (i + j) >= t) s += longint'(1) << (i + j);
    return PW'(s);
  endfunction

  // Consumer: out_ready updated shortly after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 3) != 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pushes expected results on accept, pops and compares on output transfer.
  initial begin
    logic          hold;
    logic [PW-1:0] held_z;
    hold   = 1'b0;
    held_z = '0;
    forever begin
      @(posedge clk);
      if (rst) begin
        n_acc -= sb.size();
        sb.delete();
        hold = 1'b0;
      end else begin
        if (bus.out_valid) begin
          check("in_ready_low_in_done", 32'(bus.in_ready), 0);
          if (hold) check("z_held_under_backpressure", 32'(bus.z), 32'(held_z));
          if (bus.out_ready) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL spurious_output: got z=%0d expected no output", bus.z);
            end else begin
              check("scoreboard_z", 32'(bus.z), 32'(sb.pop_front()));
            end
            n_out++;
            hold = 1'b0;
          end else begin
            hold   = 1'b1;
            held_z = bus.z;
          end
        end else begin
          hold = 1'b0;
        end
        if (bus.in_valid && bus.in_ready) begin
          sb.push_back(ref_z(int'(bus.x), int'(bus.y), int'(bus.theta)));
          n_acc++;
        end
      end
    end
  end

  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  // Present an operand pair, hold it until accepted, return at the negedge after the accept edge.
  task automatic send(input int xv, input int yv, input int tv);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x        = LENGTH'(xv);
    bus.y        = LENGTH'(yv);
    bus.theta    = TW'(tv);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) fail_now("accept_timeout");
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Counts rising edges from the accept edge to the first edge presenting out_valid.
  task automatic wait_valid(output int n);
    n = 1;
    while (!bus.out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int lat;
    int n;
    int acc0;
    logic seen;
    logic [PW-1:0] zh;

    bus.in_valid = 1'b0;
    bus.x        = '0;
    bus.y        = '0;
    bus.theta    = '0;
    rst          = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_in_ready", 32'(bus.in_ready), 1);
    check("reset_out_valid", 32'(bus.out_valid), 0);
    check("reset_busy", 32'(bus.busy), 0);
    check("reset_z", 32'(bus.z), 0);
    rst = 1'b0;

    // Exact mode and latency.
    send(255, 255, 0);
    check("calc_busy", 32'(bus.busy), 1);
    check("calc_in_ready", 32'(bus.in_ready), 0);
    wait_valid(lat);
    check("latency", 32'(lat), LENGTH + 1);
    check("z_exact_255x255", 32'(bus.z), 65025);

    // Maximum truncation.
    send(255, 255, 7);
    wait_valid(lat);
    check("z_theta7_255x255", 32'(bus.z), 64256);
    send(200, 129, 7);
    wait_valid(lat);
    check("z_theta7_200x129", 32'(bus.z), 25728);

    // Low-row masking and clamping.
    send(3, 1, 7);
    wait_valid(lat);
    check("z_3x1_theta7", 32'(bus.z), 0);
    send(3, 1, 1);
    wait_valid(lat);
    check("z_3x1_theta1", 32'(bus.z), 2);
    send(3, 1, 9);
    wait_valid(lat);
    check("z_3x1_theta9_clamped", 32'(bus.z), 0);

    // Backpressure in DONE.
    rdy_mode = 2;
    send(200, 129, 7);
    wait_valid(lat);
    zh = bus.z;
    check("bp_z", 32'(zh), 25728);
    for (int c = 0; c < 5; c++) begin
      check("bp_out_valid", 32'(bus.out_valid), 1);
      check("bp_z_stable", 32'(bus.z), 32'(zh));
      check("bp_in_ready", 32'(bus.in_ready), 0);
      @(negedge clk);
    end
    rdy_mode = 0;
    n = 0;
    while (bus.out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("bp_release_out_valid", 32'(bus.out_valid), 0);
    check("bp_release_in_ready", 32'(bus.in_ready), 1);
    send(5, 6, 0);
    wait_valid(lat);
    check("z_after_bp", 32'(bus.z), 30);

    // Inputs changing mid-CALC are ignored.
    send(100, 50, 3);
    repeat (3) begin
      bus.x     = LENGTH'($urandom_range(0, 255));
      bus.y     = LENGTH'($urandom_range(0, 255));
      bus.theta = TW'($urandom_range(0, 8));
      @(negedge clk);
    end
    wait_valid(lat);
    check("z_latched_operands", 32'(bus.z), 32'(ref_z(100, 50, 3)));

    // Reset during CALC cycle 3.
    send(77, 88, 2);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("rst_no_spurious_output", 32'(seen), 0);
    send(10, 10, 0);
    wait_valid(lat);
    check("z_after_reset", 32'(bus.z), 100);

    // Random regression with producer gaps and consumer stalls.
    rdy_mode = 1;
    acc0     = n_acc;
    for (int t = 0; t < 1000; t++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 8)));
    end
    rdy_mode = 0;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", 32'(sb.size()), 0);
    check("random_accepted", 32'(n_acc - acc0), 1000);
    check("in_out_balance", 32'(n_out), 32'(n_acc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/column_approx_seq_ctrl.md
Name: column_approx_seq_ctrl

Overview:
- Multi-cycle, runtime-configurable column-truncated approximate multiplier controller.
- Accepts one operand pair per transaction over a valid/ready handshake and latches a per-transaction truncation level THETA.
- Sequences one partial-product row per cycle through a shared masked-row generator and accumulator, then presents the product on a valid/ready output.
- Used where area matters more than throughput, as a drop-in sequential alternative to the fully parallel column-approximate multipliers.

Parameters:
- LENGTH, 8, operand width in bits; product width is 2*LENGTH.
- TW, $clog2(LENGTH+1), width of the theta input.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand transaction valid.
- in_ready  out  1  controller can accept a transaction.
- x  in  LENGTH  multiplicand, unsigned.
- y  in  LENGTH  multiplier, unsigned.
- theta  in  TW  truncation level, 0..LENGTH; values above LENGTH are treated as LENGTH.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts the product.
- z  out  2*LENGTH  approximate product, unsigned.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, z=0, accumulator=0, row counter=0.
- Approximation rule:
  - For row i (0..LENGTH-1), truncation k_i = max(theta_l - i, 0).
  - Row value = y_l[i] ? ((x_l >> k_i) << k_i) << i : 0.
  - z = sum of all rows, computed modulo 2^(2*LENGTH); no overflow is possible.
  - theta=0 gives the exact product.
  - theta=LENGTH-1 matches the fixed THETA=LENGTH-1 parallel variant.
- FSM has three states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch x_l, y_l and theta_l (clamped), clear the accumulator, set cnt=0, go to CALC.
- CALC:
  - in_ready=0, out_valid=0.
  - Each cycle: acc += row(cnt), cnt++.
  - After the row with cnt=LENGTH-1 is added, go to DONE.
  - CALC lasts exactly LENGTH cycles; zero y bits are not skipped, so latency is fixed.
- DONE:
  - out_valid=1; z=acc, held stable while out_valid&!out_ready.
  - On out_ready: go to IDLE, out_valid drops the next cycle.
  - in_ready stays 0 in DONE, so there is no overlap.
- Latency: out_valid asserts LENGTH+1 edges after the accept edge.
- Minimum initiation interval: LENGTH+2 cycles.
- Inputs x, y and theta are ignored outside the accept cycle; changing them mid-CALC has no effect.
- rst asserted in any state returns to IDLE on the next edge, discards the in-flight transaction, and drops out_valid.
- in_valid asserted during CALC or DONE is not accepted; the producer must hold it until in_ready.
- Unsigned arithmetic only. The accumulator is 2*LENGTH bits. The row shift is computed at 2*LENGTH width before the add.

Decomposition:
- Package column_approx_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the default LENGTH;
  - a function clamp_theta.
- Sub-module column_row_gen (combinational): inputs x, y_bit, row index i, theta; output the shifted, masked 2*LENGTH-bit row. It is reusable by future parallel/pipelined variants.
- The controller owns the FSM, counter, operand registers and accumulator.

Test Plan:
1. Exact mode: x=255, y=255, theta=0 -> out_valid 9 edges after accept, z=65025.
2. Max truncation: x=255, y=255, theta=7 -> z=64256. Then x=200, y=129, theta=7 -> z=25728 (exact would be 25800).
3. Low-row masking: x=3, y=1, theta=7 -> z=0. Same operands with theta=1 -> z=2. theta=9 clamps to 8 -> z=0.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> z and out_valid stable, in_ready=0 throughout. Then out_ready=1 -> IDLE next cycle, a second transaction is accepted and correct.
5. Mid-operation changes and reset: change x, y and theta during CALC -> result reflects the latched values. Assert rst at CALC cycle 3 -> next cycle IDLE, out_valid=0, in_ready=1, no spurious output. A following transaction x=10, y=10, theta=0 -> z=100.
6. Random regression: 1000 random x, y and theta (0..8) with random valid/ready stalls, checked against a reference model of the row formula; no dropped or duplicated transactions.
